dmem_responder: RTL
===================

# dmem_responder

Data-memory responder that serves load/store requests issued by the pipeline's memory-access stage. It owns a word-organised, byte-addressed RAM and executes byte, halfword and word accesses. Sub-word stores use an internal read-modify-write sequence. Requests and responses use valid/ready handshakes, so the pipeline can stall on memory latency instead of assuming a fixed one-cycle RAM.

## Interface
Parameters:
- AddrWidth, 10, word-address bits; the RAM holds 2^AddrWidth words.
- DataWidth, 32, word width; fixed at 32 for RV32 byte lanes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half data taken from the low bits.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request.

## Operation
- Word index is req_addr[AddrWidth+1:2]. Address bits above that are ignored, so addresses wrap. Byte lane is req_addr[1:0].
- The request is captured on acceptance; later changes on req_* have no effect.
- The RAM has a synchronous read and a synchronous write, one port, and contents are not reset.
- FSM states: IDLE, ACCESS, MERGE, RESP.
  - IDLE: req_ready=1. On req_valid, latch the request and go to ACCESS.
  - ACCESS: read the word into an internal register.
    - If the request is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size is 11: set err, perform no write, go to RESP.
    - Word store: write req_wdata this edge, go to RESP.
    - Byte or half store: go to MERGE.
    - Load: go to RESP.
  - MERGE: write the read word with the addressed byte or half replaced by the low bits of wdata. Other bytes are unchanged. Go to RESP.
  - RESP: resp_valid=1, with resp_rdata and resp_err stable. On resp_ready, go to IDLE.
- Load extraction:
  - Byte: select the lane, extend from bit 7.
  - Half: lane 0 or 2, extend from bit 15.
  - Word: passed through unchanged.
- Little-endian: lane 0 is bits [7:0].

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Captured-request registers are cleared to 0.
- Latency from the accepting edge (E0) to the first cycle of resp_valid:
  - Load, word store, error: 2 cycles. The ACCESS edge is E1; resp_valid is high after E1.
  - Byte or half store: 3 cycles, through MERGE at E2.
- req_ready is deasserted for the whole transaction. The minimum request-to-request spacing is 3 cycles for loads and 4 for sub-word stores, when resp_ready is held high.
- RESP holds indefinitely while resp_ready=0, and outputs stay constant.
- resp_valid and resp_ready high together: transfer completes, and req_ready=1 the next cycle. There is no same-cycle request acceptance on the response edge.
- Store-then-load to the same address returns the new data, because the write completes before the responder returns to IDLE.
- Reset mid-transaction: the state returns to IDLE at once and the response is dropped.
  - If reset is asserted before the write edge, the RAM is not written. This applies to the MERGE edge and to the ACCESS edge of a word store.
  - A write completed before reset persists.
- Error requests never modify the RAM.

## Test plan
- Word store then load: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, err=0. Load response 2 cycles after accept.
- Sub-word RMW: SW 0x11223344 @0x20, then SB 0xAA @0x21 -> LW @0x20 = 0x1122AA44. Then SH 0xBBCC @0x22 -> LW = 0xBBCCAA44. Store response 3 cycles after accept.
- Sign/zero extension with word 0x80FF7F01 @0x30:
  - LB @0x32 = 0xFFFFFFFF; LBU @0x32 = 0x000000FF.
  - LH @0x32 = 0xFFFF80FF; LHU @0x30 = 0x00007F01.
- Errors: LW @0x41 and SH @0x43 -> err=1, rdata=0, and a prior word at 0x40 is unchanged. Size 11 -> err=1.
- Backpressure: hold resp_ready=0 for 5 cycles on a load -> resp_valid and rdata stable and req_ready=0 throughout. A req_valid presented during this time is not accepted until 1 cycle after resp_ready=1.
- Reset abort: assert rst in MERGE of SB 0x55 @0x51 over word 0x00000000 -> outputs at their reset values immediately; a subsequent LW @0x50 = 0x00000000. Address wrap: SW @(0x50 + 4·2^AddrWidth) is read back by LW @0x50.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response channels between the pipeline memory stage and dmem_responder.
// Both directions are valid/ready handshakes; the responder is the slave.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM serving byte/half/word loads and stores over valid/ready channels.
// Sub-word stores read the word in ACCESS and write the merged word back in MERGE.
module dmem_responder #(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 32
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    state_t               state_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic                 resp_err_q;
    logic                 load_ok_q;
    logic                 write_q;
    logic                 unsigned_q;
    logic [1:0]           size_q;
    logic [AddrWidth+1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;

    logic [DataWidth-1:0] mem_q [2**AddrWidth];
    logic [DataWidth-1:0] word_q;

    logic [AddrWidth-1:0] idx;
    logic [1:0]           lane;
    logic                 req_err;
    logic                 mem_we;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] merged_d;
    logic [DataWidth-1:0] rdata_d;
    logic [7:0]           byte_d;
    logic [15:0]          half_d;

    // Upper address bits are ignored so the address space wraps onto the RAM.
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.req_addr[31:AddrWidth+2]};

    assign idx  = addr_q[AddrWidth+1:2];
    assign lane = addr_q[1:0];

    assign req_err = (size_q == 2'b11)
                   || (size_q == 2'b01 && lane[0])
                   || (size_q == 2'b10 && lane != 2'b00);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        merged_d = word_q;
        case (size_q)
            2'b00:   merged_d[{lane, 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged_d[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged_d = word_q;
        endcase
    end

    always_comb begin
        byte_d  = word_q[{lane, 3'b000} +: 8];
        half_d  = word_q[{lane[1], 4'b0000} +: 16];
        rdata_d = '0;
        case (size_q)
            2'b00:   rdata_d = {{(DataWidth-8){~unsigned_q & byte_d[7]}}, byte_d};
            2'b01:   rdata_d = {{(DataWidth-16){~unsigned_q & half_d[15]}}, half_d};
            2'b10:   rdata_d = word_q;
            default: rdata_d = '0;
        endcase
    end

    // Writes are keyed off the state register, so an async reset before the edge suppresses them.
    assign mem_we    = (state_q == ACCESS && write_q && size_q == 2'b10 && !req_err)
                    || (state_q == MERGE);
    assign mem_wdata = (state_q == MERGE) ? merged_d : wdata_q;

    // NOTE: the RAM array and its read register have no reset; only control state is reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
        if (state_q == ACCESS) begin
            word_q <= mem_q[idx];
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            load_ok_q    <= 1'b0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        unsigned_q  <= bus.req_unsigned;
                        size_q      <= bus.req_size;
                        addr_q      <= bus.req_addr[AddrWidth+1:0];
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (req_err) begin
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (write_q && size_q != 2'b10) begin
                        state_q <= MERGE;
                    end else begin
                        load_ok_q    <= !write_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                MERGE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        load_ok_q    <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data is driven only for successful loads; word_q is frozen while in RESP.
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = load_ok_q ? rdata_d : '0;
endmodule
